// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of the async sample FIFO.
// Owns the binary/Gray read pointer, issues 1-cycle-latency RAM reads and
// presents first-word-fall-through data through a 2-entry skid buffer.
// Optional build macro FIFO_RD_LEVEL_EN adds o_level, a registered count of
// unread RAM words. Words already held in the skid buffer are not counted.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH:0]   i_wptr_gray_sync,
  output logic [ADDR_WIDTH:0]   o_rptr_gray,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  output logic                  o_ren,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_empty
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   o_level
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  // Pointer state.
  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;

  // Read issued last cycle; its data is on i_rdata this cycle.
  logic inflight;

  // Skid buffer: head drives o_data, spare catches a return while head is stalled.
  logic                  head_v, spare_v;
  logic [DATA_WIDTH-1:0] head_q, spare_q;
  logic                  head_v_n, spare_v_n;
  logic [DATA_WIDTH-1:0] head_n, spare_n;

  // Handshake and occupancy terms.
  logic       pop;
  logic [1:0] occ;
  logic [1:0] occ_after_pop;

  // A read may be issued only while at most one word is committed after this
  // cycle's pop, so the returning word always has a free slot.
  always_comb begin
    pop           = head_v & i_ready;
    occ           = {1'b0, inflight} + {1'b0, head_v} + {1'b0, spare_v};
    occ_after_pop = occ - {1'b0, pop};
    o_ren         = ~o_empty & (occ_after_pop < 2'd2);
  end

  // Next pointer and its Gray form; the Gray value is what crosses domains.
  always_comb begin
    rbin_next  = rbin + {{(PW-1){1'b0}}, o_ren};
    rgray_next = rbin_next ^ (rbin_next >> 1);
  end

  assign o_raddr = rbin[ADDR_WIDTH-1:0];

  // Pointer, Gray export and empty flag, all taken from the post-issue pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rbin        <= '0;
      o_rptr_gray <= '0;
      o_empty     <= 1'b1;
    end else begin
      rbin        <= rbin_next;
      o_rptr_gray <= rgray_next;
      o_empty     <= (rgray_next == i_wptr_gray_sync);
    end
  end

  // Track the single outstanding RAM read; reset discards it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) inflight <= 1'b0;
    else          inflight <= o_ren;
  end

  // Skid next state: apply the pop first (spare shifts to head), then place
  // any returning word in the first free slot, preserving FIFO order.
  always_comb begin
    head_v_n  = head_v;
    spare_v_n = spare_v;
    head_n    = head_q;
    spare_n   = spare_q;
    if (pop) begin
      head_v_n  = spare_v;
      head_n    = spare_q;
      spare_v_n = 1'b0;
    end
    if (inflight) begin
      if (!head_v_n) begin
        head_v_n = 1'b1;
        head_n   = i_rdata;
      end else begin
        spare_v_n = 1'b1;
        spare_n   = i_rdata;
      end
    end
  end

  // Skid buffer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_v  <= 1'b0;
      spare_v <= 1'b0;
      head_q  <= '0;
      spare_q <= '0;
    end else begin
      head_v  <= head_v_n;
      spare_v <= spare_v_n;
      head_q  <= head_n;
      spare_q <= spare_n;
    end
  end

  assign o_data  = head_q;
  assign o_valid = head_v;

`ifdef FIFO_RD_LEVEL_EN
  // Gray to binary: bit i is the XOR of all Gray bits at or above i.
  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    for (int i = 0; i < PW; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  logic [PW-1:0] wbin_sync;
  assign wbin_sync = g2b(i_wptr_gray_sync);

  // Unread RAM words, modulo the pointer range.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_level <= '0;
    else          o_level <= wbin_sync - rbin_next;
  end
`endif

endmodule
